// File: rtl/circuit_out_ser.sv
// Serialises W-bit result frames into OW-bit ready/valid beats, least-significant beat first.
// A shift register plus one pending frame keeps the output stream free of bubbles.
module circuit_out_ser #(
  parameter int W  = 96,
  parameter int OW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_last,
  output logic [CW-1:0] frames_out,
  output logic          busy
);

  localparam int NW = W / OW;
  localparam int BW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NW - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        state;
  logic [W-1:0]  sr;
  logic [W-1:0]  pr;
  logic          pr_full;
  logic [BW-1:0] beat;
  logic          in_hs;
  logic          out_hs;
  logic          last_hs;

  // in_ready depends only on registered state, and is held low while in reset
  assign in_ready   = rst & ~pr_full;
  assign out_valid  = (state == SHIFT);
  assign out_data   = sr[OW-1:0];
  assign out_last   = out_valid & (beat == LAST_BEAT);
  assign busy       = out_valid | pr_full;

  assign in_hs   = in_valid & in_ready;
  assign out_hs  = out_valid & out_ready;
  assign last_hs = out_hs & out_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sr         <= '0;
      pr         <= '0;
      pr_full    <= 1'b0;
      beat       <= '0;
      frames_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_hs) begin
            sr    <= in_data;
            beat  <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (out_hs && !out_last) begin
            sr   <= sr >> OW;
            beat <= beat + BW'(1);
          end else if (last_hs) begin
            frames_out <= frames_out + CW'(1);
            beat       <= '0;
            // pending frame wins; otherwise a frame arriving on this edge bypasses PR
            if (pr_full) begin
              sr      <= pr;
              pr_full <= 1'b0;
            end else if (in_hs) begin
              sr <= in_data;
            end else begin
              state <= IDLE;
            end
          end
          if (in_hs && !last_hs) begin
            pr      <= in_data;
            pr_full <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circuit_out_ser.sv
// Directed bench for circuit_out_ser: reset, single frame, back-to-back, backpressure,
// bypass, asynchronous reset mid-frame and frame-counter wrap.
module tb_circuit_out_ser;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [15:0] frames_out;
  logic        busy;

  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_data2;
  logic        out_last2;
  logic [1:0]  frames2;
  logic        busy2;

  int total = 0;
  int bad = 0;
  int exp_frames = 0;

  circuit_out_ser #(.W(96), .OW(32), .CW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frames_out(frames_out), .busy(busy)
  );

  circuit_out_ser #(.W(96), .OW(32), .CW(2)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_last(out_last2),
    .frames_out(frames2), .busy(busy2)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] mk(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    #3;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_in_ready got=%0h want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid got=%0h want=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("[TB] FAIL rst_out_data got=%0h want=0", out_data); end
    total++; if (out_last !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_last got=%0h want=0", out_last); end
    total++; if (frames_out !== 16'h0) begin bad++; $display("[TB] FAIL rst_frames got=%0h want=0", frames_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%0h want=0", busy); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rel_in_ready got=%0h want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rel_out_valid got=%0h want=0", out_valid); end
  endtask

  task automatic test_single_frame();
    in_data = mk(32'h0); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid k=%0d got=%0h want=1", k, out_valid); end
      total++; if (out_data !== 32'(k + 1)) begin bad++; $display("[TB] FAIL single_data k=%0d got=%0h want=%0h", k, out_data, k + 1); end
      total++; if (out_last !== (k == 2)) begin bad++; $display("[TB] FAIL single_last k=%0d got=%0h want=%0h", k, out_last, k == 2); end
      tick();
    end
    exp_frames++;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_idle got=%0h want=0", out_valid); end
    total++; if (frames_out !== 16'(exp_frames)) begin bad++; $display("[TB] FAIL single_frames got=%0h want=%0h", frames_out, exp_frames); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy got=%0h want=0", busy); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int idx = 0;
    int c = -1;
    logic hs_in, hs_out, exp_rdy;
    logic [31:0] exp_beat;
    in_data = mk(32'h100); in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && idx < 12; cyc++) begin
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (out_valid) begin
        exp_beat = 32'h100 * 32'(idx / 3 + 1) + 32'(idx % 3 + 1);
        total++; if (out_data !== exp_beat) begin bad++; $display("[TB] FAIL b2b_data idx=%0d got=%0h want=%0h", idx, out_data, exp_beat); end
        total++; if (out_last !== (idx % 3 == 2)) begin bad++; $display("[TB] FAIL b2b_last idx=%0d got=%0h want=%0h", idx, out_last, idx % 3 == 2); end
      end
      if (hs_out) idx++;
      tick();
      if (hs_in) begin
        sent++;
        if (sent < 4) in_data = mk(32'h100 * 32'(sent + 1));
        else in_valid = 1'b0;
      end
      if (sent > 0) c++;
      if (c >= 0 && c < 9) begin
        exp_rdy = (c % 3 == 0);
        total++; if (in_ready !== exp_rdy) begin bad++; $display("[TB] FAIL b2b_in_ready c=%0d got=%0h want=%0h", c, in_ready, exp_rdy); end
      end
      if (sent > 0 && idx < 12) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_gap idx=%0d got=%0h want=1", idx, out_valid); end
      end
    end
    exp_frames += 4;
    total++; if (idx != 12) begin bad++; $display("[TB] FAIL b2b_beats got=%0d want=12", idx); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle got=%0h want=0", out_valid); end
    total++; if (frames_out !== 16'(exp_frames)) begin bad++; $display("[TB] FAIL b2b_frames got=%0h want=%0h", frames_out, exp_frames); end
  endtask

  task automatic test_backpressure();
    logic [31:0] seq [5];
    seq = '{32'h202, 32'h203, 32'h301, 32'h302, 32'h303};
    in_data = mk(32'h200); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_data = mk(32'h300);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid s=%0d got=%0h want=1", s, out_valid); end
      total++; if (out_data !== 32'h202) begin bad++; $display("[TB] FAIL bp_data s=%0d got=%0h want=202", s, out_data); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready s=%0d got=%0h want=0", s, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_resume_valid j=%0d got=%0h want=1", j, out_valid); end
      total++; if (out_data !== seq[j]) begin bad++; $display("[TB] FAIL bp_resume_data j=%0d got=%0h want=%0h", j, out_data, seq[j]); end
      tick();
    end
    exp_frames += 2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_idle got=%0h want=0", out_valid); end
    total++; if (frames_out !== 16'(exp_frames)) begin bad++; $display("[TB] FAIL bp_frames got=%0h want=%0h", frames_out, exp_frames); end
  endtask

  task automatic test_bypass();
    in_data = mk(32'h400); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    total++; if (out_last !== 1'b1) begin bad++; $display("[TB] FAIL byp_last got=%0h want=1", out_last); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL byp_in_ready got=%0h want=1", in_ready); end
    in_data = mk(32'h500); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL byp_valid k=%0d got=%0h want=1", k, out_valid); end
      total++; if (out_data !== 32'h500 + 32'(k + 1)) begin bad++; $display("[TB] FAIL byp_data k=%0d got=%0h want=%0h", k, out_data, 32'h500 + k + 1); end
      tick();
    end
    exp_frames += 2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL byp_idle got=%0h want=0", out_valid); end
    total++; if (frames_out !== 16'(exp_frames)) begin bad++; $display("[TB] FAIL byp_frames got=%0h want=%0h", frames_out, exp_frames); end
  endtask

  task automatic test_reset_mid_frame();
    in_data = mk(32'h600); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (out_data !== 32'h601) begin bad++; $display("[TB] FAIL mid_beat0 got=%0h want=601", out_data); end
    tick();
    #2;
    rst = 1'b0;
    #1;
    exp_frames = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_valid got=%0h want=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("[TB] FAIL mid_rst_data got=%0h want=0", out_data); end
    total++; if (frames_out !== 16'h0) begin bad++; $display("[TB] FAIL mid_rst_frames got=%0h want=0", frames_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_busy got=%0h want=0", busy); end
    @(negedge clk);
    rst = 1'b1;
    in_data = mk(32'h700); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++; if (out_data !== 32'h700 + 32'(k + 1)) begin bad++; $display("[TB] FAIL mid_fresh k=%0d got=%0h want=%0h", k, out_data, 32'h700 + k + 1); end
      total++; if (out_last !== (k == 2)) begin bad++; $display("[TB] FAIL mid_fresh_last k=%0d got=%0h want=%0h", k, out_last, k == 2); end
      tick();
    end
    exp_frames++;
    total++; if (frames_out !== 16'(exp_frames)) begin bad++; $display("[TB] FAIL mid_frames got=%0h want=%0h", frames_out, exp_frames); end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      in_data = mk(32'h800 + 32'h10 * 32'(f)); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      total++; if (frames2 !== exp_seq[f]) begin bad++; $display("[TB] FAIL wrap_frames f=%0d got=%0h want=%0h", f, frames2, exp_seq[f]); end
      total++; if (out_valid2 !== 1'b0) begin bad++; $display("[TB] FAIL wrap_idle f=%0d got=%0h want=0", f, out_valid2); end
    end
    total++; if (frames_out !== 16'd5) begin bad++; $display("[TB] FAIL wrap_main_frames got=%0h want=5", frames_out); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_bypass();
    test_reset_mid_frame();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
